// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-stage synchroniser/filter.
//   MIN_STAGES : smallest legal synchroniser depth
//   MIN_FILT   : smallest legal filter acceptance count
//   clog2()    : ceiling log2, usable at elaboration time
package sync_pkg;

  localparam int unsigned MIN_STAGES = 2;
  localparam int unsigned MIN_FILT   = 1;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel of the synchroniser: flop chain, optional glitch filter,
// previous-level register and rise/fall pulse generation.
// Build option: SYNC_FILTER_EN defined builds the glitch filter; otherwise
// the output level is the last synchroniser flop.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : asynchronous level input
//   dout       : synchronised (and filtered) level
//   rise, fall : one-cycle pulses on 0->1 / 1->0 of dout
module sync_filter_chan
  import sync_pkg::*;
#(
  parameter int unsigned STAGES = MIN_STAGES
`ifdef SYNC_FILTER_EN
  , parameter int unsigned FILT_CYCLES = MIN_FILT
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] stage;
  logic              sync_q;
  logic              prev;

  // Synchroniser chain; stage[0] is the metastability-exposed flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage <= '0;
    else        stage <= {stage[STAGES-2:0], din};
  end

  assign sync_q = stage[STAGES-1];

`ifdef SYNC_FILTER_EN
  localparam int unsigned CNT_W = (clog2(FILT_CYCLES) > 1) ? clog2(FILT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;

  // Accept a new level only after FILT_CYCLES consecutive differing samples;
  // any matching sample restarts the count.
  always_comb begin
    cnt_nxt   = '0;
    level_nxt = dout;
    if (sync_q != dout) begin
      if (cnt == CNT_MAX) level_nxt = sync_q;
      else                cnt_nxt   = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      dout <= level_nxt;
    end
  end
`else
  assign dout = sync_q;
`endif

  // Level one cycle ago, for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= dout;
  end

  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/multi_stage_sync_filter.sv
// Brings WIDTH independent asynchronous levels into the clk domain through a
// STAGES-deep synchroniser, with an optional per-channel glitch filter and
// per-channel rise/fall pulses.
// Build option: SYNC_FILTER_EN (defined = glitch filter built, FILT_CYCLES used).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   data_in     : WIDTH asynchronous level inputs
//   data_out    : WIDTH synchronised (filtered) levels
//   rise_pulse  : WIDTH one-cycle 0->1 pulses
//   fall_pulse  : WIDTH one-cycle 1->0 pulses
//   any_change  : OR of all rise/fall pulses
module multi_stage_sync_filter
  import sync_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STAGES      = 2,
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  // Elaboration-time parameter checks.
  if (WIDTH < 1) begin : g_bad_width
    $error("multi_stage_sync_filter: WIDTH must be >= 1");
  end
  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("multi_stage_sync_filter: STAGES must be >= %0d", MIN_STAGES);
  end
  if (FILT_CYCLES < MIN_FILT) begin : g_bad_filt
    $error("multi_stage_sync_filter: FILT_CYCLES must be >= %0d", MIN_FILT);
  end

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_chan
    sync_filter_chan #(
      .STAGES      (STAGES)
`ifdef SYNC_FILTER_EN
      , .FILT_CYCLES (FILT_CYCLES)
`endif
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (data_in[g]),
      .dout  (data_out[g]),
      .rise  (rise_pulse[g]),
      .fall  (fall_pulse[g])
    );
  end

  assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_multi_stage_sync_filter.sv
// Self-checking bench for multi_stage_sync_filter. A sample-history model
// predicts every output each cycle; directed steps pin literal expectations.
module tb_multi_stage_sync_filter;

  localparam int unsigned W = 8;
`ifdef SYNC_FILTER_EN
  localparam int unsigned S   = 2;
  localparam int unsigned F   = 4;
  localparam int unsigned LAT = S + F;
`else
  localparam int unsigned S   = 3;
  localparam int unsigned F   = 4;
  localparam int unsigned LAT = S;
`endif
  localparam int unsigned HIST = S + F;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out, rise_pulse, fall_pulse;
  logic         any_change;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_stage_sync_filter #(
    .WIDTH       (W),
    .STAGES      (S),
    .FILT_CYCLES (F)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_out   (data_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .any_change (any_change)
  );

  // Model: hist[k] = data_in sampled k edges ago (0 = this edge).
  logic [W-1:0] hist [HIST];
  logic [W-1:0] m_out  = '0;
  logic [W-1:0] m_prev = '0;

  task automatic model_reset();
    for (int k = 0; k < int'(HIST); k++) hist[k] = '0;
    m_out  = '0;
    m_prev = '0;
  endtask

  task automatic model_step(input logic [W-1:0] din);
    logic [W-1:0] nxt;
    logic         flip;
    for (int k = int'(HIST) - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = din;
`ifdef SYNC_FILTER_EN
    // Level flips when the last F synchronised samples all differ from it.
    for (int i = 0; i < int'(W); i++) begin
      flip = 1'b1;
      for (int k = int'(S); k < int'(S + F); k++)
        if (hist[k][i] == m_out[i]) flip = 1'b0;
      nxt[i] = flip ? ~m_out[i] : m_out[i];
    end
`else
    nxt = hist[S-1];
`endif
    m_prev = m_out;
    m_out  = nxt;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step(data_in);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    chk("model data_out",   32'(data_out),   32'(m_out));
    chk("model rise_pulse", 32'(rise_pulse), 32'(m_out & ~m_prev));
    chk("model fall_pulse", 32'(fall_pulse), 32'(~m_out & m_prev));
    chk("model any_change", 32'(any_change), 32'(|(m_out ^ m_prev)));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // 1: reset with inputs high, then release.
    rst_n   = 1'b0;
    data_in = 8'hFF;
    tick(3);
    chk("reset data_out", 32'(data_out), 32'h00);
    chk("reset rise",     32'(rise_pulse), 32'h00);
    chk("reset any",      32'(any_change), 32'h0);
    rst_n = 1'b1;
    tick(int'(LAT) - 1);
    chk("release pre-latency data_out", 32'(data_out), 32'h00);
    tick(1);
    chk("release data_out", 32'(data_out), 32'hFF);
    chk("release rise",     32'(rise_pulse), 32'hFF);
    chk("release any",      32'(any_change), 32'h1);
    tick(1);
    chk("release rise once", 32'(rise_pulse), 32'h00);

    // 2: single-channel latency.
    data_in = 8'h00;
    tick(int'(LAT) + 2);
    chk("settle low", 32'(data_out), 32'h00);
    data_in = 8'h01;
    tick(int'(LAT) - 1);
    chk("latency early", 32'(data_out), 32'h00);
    tick(1);
    chk("latency data_out", 32'(data_out), 32'h01);
    chk("latency rise",     32'(rise_pulse), 32'h01);
    tick(1);
    chk("latency rise once", 32'(rise_pulse), 32'h00);

`ifdef SYNC_FILTER_EN
    // 3: 3-cycle glitch on bit 3 is rejected.
    data_in = 8'h09;
    tick(3);
    data_in = 8'h01;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("glitch data_out", 32'(data_out), 32'h01);
      chk("glitch any",      32'(any_change), 32'h0);
    end
`else
    // 6: unfiltered 1-cycle glitch passes through with both pulses.
    data_in = 8'h09;
    tick(1);
    data_in = 8'h01;
    tick(int'(S) - 2);
    chk("glitch pre", 32'(data_out), 32'h01);
    tick(1);
    chk("glitch data_out", 32'(data_out), 32'h09);
    chk("glitch rise",     32'(rise_pulse), 32'h08);
    tick(1);
    chk("glitch back",     32'(data_out), 32'h01);
    chk("glitch fall",     32'(fall_pulse), 32'h08);
    chk("glitch no rise",  32'(rise_pulse), 32'h00);
    tick(1);
    chk("glitch quiet",    32'(any_change), 32'h0);
`endif

    // 4: simultaneous multi-channel change.
    data_in = 8'h0F;
    tick(int'(LAT) + 2);
    chk("multi settle", 32'(data_out), 32'h0F);
    data_in = 8'hF0;
    tick(int'(LAT) - 1);
    chk("multi early any", 32'(any_change), 32'h0);
    chk("multi early out", 32'(data_out), 32'h0F);
    tick(1);
    chk("multi data_out", 32'(data_out), 32'hF0);
    chk("multi rise",     32'(rise_pulse), 32'hF0);
    chk("multi fall",     32'(fall_pulse), 32'h0F);
    chk("multi any",      32'(any_change), 32'h1);
    tick(1);
    chk("multi any once", 32'(any_change), 32'h0);

    // 5: reset part-way through a 0->1 acceptance on bit 0.
    data_in = 8'hF1;
    tick(4);
    rst_n   = 1'b0;
    data_in = 8'h00;
    #1;
    chk("midreset async clear", 32'(data_out), 32'h00);
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < int'(LAT) + 4; i++) begin
      tick(1);
      chk("midreset data_out", 32'(data_out), 32'h00);
      chk("midreset any",      32'(any_change), 32'h0);
    end

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
